// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the fetch-side PC sequencer.
// State encoding, next-PC source select and the target legality check.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      SRC_SEQ   = 3'd0,
      SRC_JUMP  = 3'd1,
      SRC_EXRED = 3'd2,
      SRC_HOLD  = 3'd3,
      SRC_FAULT = 3'd4
   } src_t;

   localparam logic [31:0] PC_STEP = 32'd4;

   // A fetch target must be word aligned and must not exceed the top of program memory.
   function automatic logic target_illegal(input logic [31:0] target,
                                           input logic [31:0] max_addr);
      return (target > max_addr) || (target[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over inc.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             Clock,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge Clock) begin
      if (clear)
         count <= '0;
      else if (inc && (count != {WIDTH{1'b1}}))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for the pipelined MIPS fetch stage: boot hold, run/halt FSM,
// priority redirect mux with bounds/alignment fault, and stall/redirect counters.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] MAX_ADDR     = 32'd2048,
   parameter int          BOOT_CYCLES  = 1,
   parameter int          CNT_W        = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [31:0]      PC,
   input  logic             StallIF,
   input  logic             ExRedirect,
   input  logic [31:0]      ExTarget,
   input  logic             IdJump,
   input  logic [31:0]      IdTarget,
   input  logic             HaltReq,
   input  logic             Resume,
   output logic [31:0]      NewPC,
   output logic             WriteEnable,
   output logic             FlushIFID,
   output logic             FlushIDEX,
   output logic             Fault,
   output logic             Halted,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] RedirectCount
);

   localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES - 1);

   state_t      state;
   logic [3:0]  boot_cnt;
   src_t        src;
   logic [31:0] target;
   logic [32:0] seq_sum;
   logic        running;
   logic        stall_inc;
   logic        redirect_inc;

   assign running = (state == RUN) && !Reset;
   // The carry bit catches PC+4 wrapping through zero, which must also fault.
   assign seq_sum = {1'b0, PC} + {1'b0, PC_STEP};

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= BOOT;
         boot_cnt <= BOOT_INIT;
         Halted   <= 1'b0;
      end else begin
         case (state)
            BOOT: begin
               if (boot_cnt == 4'd0)
                  state <= RUN;
               else
                  boot_cnt <= boot_cnt - 4'd1;
            end
            RUN: begin
               if (HaltReq) begin
                  state  <= HALT;
                  Halted <= 1'b1;
               end
            end
            HALT: begin
               if (Resume) begin
                  state  <= RUN;
                  Halted <= 1'b0;
               end
            end
            default: begin
               state    <= BOOT;
               boot_cnt <= BOOT_INIT;
               Halted   <= 1'b0;
            end
         endcase
      end
   end

   // NOTE: every output of this block gets a default first so no path leaves a
   // value unassigned and infers a latch.
   always_comb begin
      src         = SRC_HOLD;
      target      = PC;
      WriteEnable = 1'b0;
      FlushIFID   = 1'b0;
      FlushIDEX   = 1'b0;
      if (running) begin
         if (ExRedirect) begin
            src         = SRC_EXRED;
            target      = ExTarget;
            WriteEnable = 1'b1;
            FlushIFID   = 1'b1;
            FlushIDEX   = 1'b1;
         end else if (StallIF) begin
            src = SRC_HOLD;
         end else if (IdJump) begin
            src         = SRC_JUMP;
            target      = IdTarget;
            WriteEnable = 1'b1;
            FlushIFID   = 1'b1;
         end else begin
            src         = SRC_SEQ;
            target      = seq_sum[31:0];
            WriteEnable = 1'b1;
         end
         if ((src != SRC_HOLD) &&
             (target_illegal(target, MAX_ADDR) || ((src == SRC_SEQ) && seq_sum[32])))
            src = SRC_FAULT;
      end
   end

   always_comb begin
      case (src)
         SRC_SEQ:   NewPC = seq_sum[31:0];
         SRC_JUMP:  NewPC = IdTarget;
         SRC_EXRED: NewPC = ExTarget;
         SRC_FAULT: NewPC = RESET_VECTOR;
         SRC_HOLD:  NewPC = (!Reset && ((state == RUN) || (state == HALT))) ? PC : RESET_VECTOR;
         default:   NewPC = RESET_VECTOR;
      endcase
   end

   assign Fault = (src == SRC_FAULT);

   // A redirect wins over a stall, so that cycle is counted as a redirect only.
   assign stall_inc    = running && StallIF && !ExRedirect;
   assign redirect_inc = running && (ExRedirect || (!StallIF && IdJump));

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .Clock (Clock),
      .clear (Reset),
      .inc   (stall_inc),
      .count (StallCount)
   );

   sat_counter #(.WIDTH(CNT_W)) u_redirect_cnt (
      .Clock (Clock),
      .clear (Reset),
      .inc   (redirect_inc),
      .count (RedirectCount)
   );

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-side controller that sequences the 32-bit program counter register of the pipelined MIPS datapath.
- Each cycle it decides the next-PC source: sequential, ID-stage jump, EX-stage branch/jr redirect, or fault vector. It drives NewPC and WriteEnable and issues pipeline flushes.
- Owns a post-reset boot hold, a halt state, bounds/alignment fault detection, and saturating stall/redirect performance counters.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address and fault-recovery address
- MAX_ADDR, 2048, highest legal fetch address; any target > MAX_ADDR is a fault
- BOOT_CYCLES, 1, cycles WriteEnable is held low after Reset deasserts (1..15)
- CNT_W, 16, width of the performance counters

Ports:
- Clock  in  1  system clock, all state updates on posedge
- Reset  in  1  synchronous, active-high reset
- PC  in  32  current PC register value
- StallIF  in  1  load-use hazard: hold PC and IF/ID
- ExRedirect  in  1  EX-stage taken branch or jr
- ExTarget  in  32  EX redirect target
- IdJump  in  1  ID-stage j/jal
- IdTarget  in  32  jump target
- HaltReq  in  1  break/halt instruction retired
- Resume  in  1  leave HALT
- NewPC  out  32  next PC to the PC register
- WriteEnable  out  1  PC register load enable
- FlushIFID  out  1  squash IF/ID
- FlushIDEX  out  1  squash ID/EX
- Fault  out  1  one-cycle pulse: illegal target replaced by RESET_VECTOR
- Halted  out  1  high while in HALT
- StallCount  out  CNT_W  saturating count of stall cycles
- RedirectCount  out  CNT_W  saturating count of applied redirects (ExRedirect + IdJump)

Behaviour:
- Clock and reset: one clock, Clock; reset is synchronous and active-high, Reset.
- Timing: state and counters are registered. NewPC, WriteEnable, Flush*, and Fault are combinational from the current state and inputs (same-cycle). PC loads NewPC at the edge ending that cycle.
- Reset: state=BOOT, boot counter=BOOT_CYCLES-1, counters=0. Halted=0. All outputs low. NewPC=RESET_VECTOR.
- BOOT:
  - WriteEnable=0, NewPC=RESET_VECTOR; all redirect/stall inputs ignored.
  - Decrement the boot counter each cycle; at 0 go to RUN.
- RUN next-PC selection, in strict priority order:
  1. ExRedirect: NewPC=ExTarget, WriteEnable=1, FlushIFID=1, FlushIDEX=1. Overrides StallIF and IdJump, because the younger jump is squashed.
  2. StallIF: WriteEnable=0, NewPC=PC, no flush. A concurrent IdJump is ignored; the jump re-presents after the stall.
  3. IdJump: NewPC=IdTarget, WriteEnable=1, FlushIFID=1.
  4. Otherwise: NewPC=PC+4, WriteEnable=1.
- Target check (applies to the selected target in cases 1, 3 and 4): if the target is > MAX_ADDR or target[1:0]!=0, then NewPC=RESET_VECTOR, Fault=1 for that cycle, and flushes are as in the selected case. PC+4 wraparound past MAX_ADDR is therefore a fault.
- HaltReq in RUN:
  - Takes effect after the current cycle's selection: that cycle behaves normally, then the next state is HALT.
  - If ExRedirect is asserted in the same cycle, the redirect applies and HALT is still entered.
- HALT:
  - Halted=1, WriteEnable=0, no flushes.
  - Resume → RUN next cycle. HaltReq is ignored while in HALT.
- StallCount: +1 each RUN cycle where StallIF=1 and ExRedirect=0. Saturates at all-ones.
- RedirectCount: +1 each RUN cycle where case 1 or case 3 is applied. Saturates. Faulted redirects still count.
- Reset mid-operation (any state): next cycle is BOOT with counters cleared. Reset has priority over every input.
- Unknown state encoding: recover to BOOT.

Decomposition:
- Package pc_seq_pkg:
  - state enum {BOOT, RUN, HALT}
  - next-PC source select enum {SRC_SEQ, SRC_JUMP, SRC_EXRED, SRC_HOLD, SRC_FAULT}
  - constant PC_STEP=4
- One sub-module sat_counter (parameter width; ports inc, clear), instantiated twice.
- FSM, priority mux and target check stay in pc_sequencer.

Test Plan:
- Reset 3 cycles, BOOT_CYCLES=1, release → first cycle WriteEnable=0 and NewPC=0; next cycle WriteEnable=1 and NewPC=PC+4 (PC=0 gives 4).
- RUN, PC=0x40, ExRedirect=1 with ExTarget=0x100, IdJump=1 with IdTarget=0x200, StallIF=1 all together → NewPC=0x100, WriteEnable=1, FlushIFID=FlushIDEX=1, RedirectCount +1, StallCount unchanged.
- PC=0x80, StallIF=1 for 3 cycles with IdJump=1 and IdTarget=0x300 → WriteEnable=0 for 3 cycles and StallCount=3. On the 4th cycle (StallIF=0) NewPC=0x300 and FlushIFID=1.
- PC=0x800 (2048), no redirect → target 0x804 is illegal: NewPC=0, Fault=1 for one cycle. Separately, IdTarget=0x102 → Fault=1 and NewPC=0.
- HaltReq=1 at PC=0x20 → that cycle NewPC=0x24; then Halted=1 and WriteEnable=0 until Resume. One cycle after Resume, WriteEnable=1.
- CNT_W=4 with 20 stall cycles → StallCount saturates at 15. Then Reset mid-stall → counters read 0 and state is BOOT.
